// File: rtl/sp_pkg.sv
// Shared definitions for the shortest-path query path.
// Holds the direction encodings, the "no answer" sentinel values, the default
// map size and the query arbiter state type.
package sp_pkg;

   localparam int SP_COORD_W  = 10;
   localparam int SP_DIST_W   = 10;
   localparam int SP_DIR_W    = 3;
   localparam int SP_MAP_ROWS = 30;
   localparam int SP_MAP_COLS = 40;

   typedef enum logic [SP_DIR_W-1:0] {
      SP_DIR_NONE    = 3'd0,
      SP_DIR_UP      = 3'd1,
      SP_DIR_DOWN    = 3'd2,
      SP_DIR_LEFT    = 3'd3,
      SP_DIR_RIGHT   = 3'd4,
      SP_DIR_INVALID = 3'd7
   } sp_dir_e;

   localparam logic [SP_DIST_W-1:0] SP_DIST_INF = 10'h3FF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DELIVER = 2'd2
   } sp_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans req starting one above ptr, wrapping, and reports the first set bit.
//   req       : request vector
//   ptr       : last granted index
//   id        : winning index (0 when nothing is requested)
//   any_valid : at least one request is set
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] id,
   output logic            any_valid
);

   logic [ID_W-1:0] idx;

   always_comb begin
      id        = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = 1; k <= N; k++) begin
         idx = ID_W'((int'(ptr) + k) % N);
         if (!any_valid && req[idx]) begin
            any_valid = 1'b1;
            id        = idx;
         end
      end
   end

endmodule

// File: rtl/sp_query_arbiter.sv
// Time-shares the single shortest-path query port among N_REQ requesters.
// One transaction in flight; the coordinates are held on q_r/q_c while the
// port settles, then the answer is returned with a one-cycle one-hot pulse.
//   clk, rst          : clock, async active-low reset
//   req, req_r, req_c : per-requester level request and flattened coordinates
//   sp_stable         : path table is settled
//   q_r, q_c          : coordinates to the shared query port
//   sp_dir, sp_dist   : answer from the shared query port
//   resp_valid        : one-hot response pulse
//   resp_dir/dist     : registered answer, broadcast to all requesters
//   busy              : transaction in progress
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | sample req (only when sp_stable), pick round-robin winner
// ST_WAIT    | coordinates held, counting down the port latency
// ST_DELIVER | resp_valid pulses for the granted requester
module sp_query_arbiter import sp_pkg::*; #(
   parameter int N_REQ    = 4,
   parameter int LAT      = 2,
   parameter int MAP_ROWS = SP_MAP_ROWS,
   parameter int MAP_COLS = SP_MAP_COLS
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*SP_COORD_W-1:0] req_r,
   input  logic [N_REQ*SP_COORD_W-1:0] req_c,
   input  logic                       sp_stable,
   output logic [SP_COORD_W-1:0]      q_r,
   output logic [SP_COORD_W-1:0]      q_c,
   input  logic [SP_DIR_W-1:0]        sp_dir,
   input  logic [SP_DIST_W-1:0]       sp_dist,
   output logic [N_REQ-1:0]           resp_valid,
   output logic [SP_DIR_W-1:0]        resp_dir,
   output logic [SP_DIST_W-1:0]       resp_dist,
   output logic                       busy
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(LAT + 1);

   sp_arb_state_e   state, state_nxt;
   logic [ID_W-1:0] ptr, id, pick_id;
   logic            pick_any;
   logic [CNT_W-1:0] cnt;
   logic [SP_COORD_W-1:0] r_arr [N_REQ];
   logic [SP_COORD_W-1:0] c_arr [N_REQ];
   logic [SP_COORD_W-1:0] sel_r, sel_c;
   logic            grant, sel_oor, wait_done;

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign r_arr[i] = req_r[i*SP_COORD_W +: SP_COORD_W];
      assign c_arr[i] = req_c[i*SP_COORD_W +: SP_COORD_W];
   end

   rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_rr_pick (
      .req       (req),
      .ptr       (ptr),
      .id        (pick_id),
      .any_valid (pick_any)
   );

   assign sel_r     = r_arr[pick_id];
   assign sel_c     = c_arr[pick_id];
   assign sel_oor   = (sel_r >= SP_COORD_W'(MAP_ROWS)) || (sel_c >= SP_COORD_W'(MAP_COLS));
   assign grant     = (state == ST_IDLE) && sp_stable && pick_any;
   assign wait_done = (state == ST_WAIT) && sp_stable && (cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (grant) state_nxt = sel_oor ? ST_DELIVER : ST_WAIT;
         ST_WAIT:    if (wait_done) state_nxt = ST_DELIVER;
         ST_DELIVER: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr       <= ID_W'(N_REQ - 1);
         id        <= '0;
         cnt       <= '0;
         q_r       <= '0;
         q_c       <= '0;
         resp_dir  <= '0;
         resp_dist <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  ptr <= pick_id;
                  id  <= pick_id;
                  if (sel_oor) begin
                     // q_r/q_c keep the previous query; answer is the sentinel
                     resp_dir  <= SP_DIR_INVALID;
                     resp_dist <= SP_DIST_INF;
                  end else begin
                     q_r <= sel_r;
                     q_c <= sel_c;
                     cnt <= CNT_W'(LAT);
                  end
               end
            end
            ST_WAIT: begin
               // any unsettled cycle restarts the full latency window
               if (!sp_stable) begin
                  cnt <= CNT_W'(LAT);
               end else if (cnt == CNT_W'(1)) begin
                  resp_dir  <= sp_dir;
                  resp_dist <= sp_dist;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign resp_valid = (state == ST_DELIVER) ? (N_REQ'(1) << id) : '0;
   assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_sp_query_arbiter.sv
module tb_sp_query_arbiter;

   localparam int N_REQ = 4;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [39:0] req_r = '0;
   logic [39:0] req_c = '0;
   logic        sp_stable = 1'b1;
   logic [9:0]  q_r, q_c;
   logic [2:0]  sp_dir = '0;
   logic [9:0]  sp_dist = '0;
   logic [3:0]  resp_valid;
   logic [2:0]  resp_dir;
   logic [9:0]  resp_dist;
   logic        busy;
   logic [2:0]  stub_dir = '0;

   int n_checks = 0;
   int n_fail   = 0;

   sp_query_arbiter #(.N_REQ(N_REQ), .LAT(LAT), .MAP_ROWS(30), .MAP_COLS(40)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_r      (req_r),
      .req_c      (req_c),
      .sp_stable  (sp_stable),
      .q_r        (q_r),
      .q_c        (q_c),
      .sp_dir     (sp_dir),
      .sp_dist    (sp_dist),
      .resp_valid (resp_valid),
      .resp_dir   (resp_dir),
      .resp_dist  (resp_dist),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // shared-port stub: answer is valid LAT-1 registers after q settles
   always @(posedge clk) begin
      sp_dist <= q_r + q_c;
      sp_dir  <= stub_dir;
   end

   typedef struct {
      logic [3:0] vreq;
      int         rb;
      int         cb;
      logic [2:0] sdir;
      int         exp_id;
      int         exp_qr;
      int         exp_qc;
      int         exp_dir;
      int         exp_dist;
      int         exp_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coords(input int rb, input int cb);
      for (int i = 0; i < N_REQ; i++) begin
         req_r[i*10 +: 10] = 10'(rb + i);
         req_c[i*10 +: 10] = 10'(cb + 2*i);
      end
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (resp_valid == '0 && n < 20);
      if (resp_valid == '0) begin
         n_checks++;
         n_fail++;
         $display("FAIL resp_timeout: no resp_valid within %0d cycles", n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int any_pulse;

      //          req      rb  cb  sdir id  qr  qc  dir dist   lat
      vecs[0] = '{4'b0100,  3,  3, 3'd3, 2,  5,  7,  3,  12,    3};
      vecs[1] = '{4'b1111,  1,  1, 3'd1, 3,  4,  7,  1,  11,    3};
      vecs[2] = '{4'b1111, 10, 20, 3'd4, 0, 10, 20,  4,  30,    3};
      vecs[3] = '{4'b0010, 29,  0, 3'd2, 1, 10, 20,  7,  'h3FF, 1};
      vecs[4] = '{4'b0011, 29, 39, 3'd2, 0, 29, 39,  2,  68,    3};
      vecs[5] = '{4'b0011,  0, 38, 3'd4, 1, 29, 39,  7,  'h3FF, 1};
      vecs[6] = '{4'b1001,  0,  0, 3'd0, 3,  3,  6,  0,  9,     3};
      vecs[7] = '{4'b1001,  7,  2, 3'd1, 0,  7,  2,  1,  9,     3};

      // reset state
      step();
      step();
      check("rst_q_r", q_r, 0);
      check("rst_q_c", q_c, 0);
      check("rst_resp_dir", resp_dir, 0);
      check("rst_resp_dist", resp_dist, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;
      step();

      // table-driven single transactions; pointer carries across rows
      for (int i = 0; i < 8; i++) begin
         set_coords(vecs[i].rb, vecs[i].cb);
         stub_dir = vecs[i].sdir;
         req = vecs[i].vreq;
         wait_resp(n);
         check($sformatf("v%0d_latency", i), n, vecs[i].exp_lat);
         check($sformatf("v%0d_resp_valid", i), resp_valid, 1 << vecs[i].exp_id);
         check($sformatf("v%0d_resp_dir", i), resp_dir, vecs[i].exp_dir);
         check($sformatf("v%0d_resp_dist", i), resp_dist, vecs[i].exp_dist);
         check($sformatf("v%0d_q_r", i), q_r, vecs[i].exp_qr);
         check($sformatf("v%0d_q_c", i), q_c, vecs[i].exp_qc);
         req = '0;
         step();
         check($sformatf("v%0d_pulse_width", i), resp_valid, 0);
         check($sformatf("v%0d_idle_busy", i), busy, 0);
      end

      // all four requesting continuously right after reset
      rst = 1'b0;
      step();
      rst = 1'b1;
      set_coords(1, 1);
      stub_dir = 3'd2;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_resp(n);
         check($sformatf("rr_order_%0d", k), resp_valid, 1 << (k % 4));
         check($sformatf("rr_spacing_%0d", k), n, (k == 0) ? LAT + 1 : LAT + 2);
      end
      req = '0;
      step();

      // stability stall; pointer now 0
      set_coords(2, 2);
      stub_dir = 3'd4;
      sp_stable = 1'b0;
      req = 4'b0100;
      any_pulse = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (busy || resp_valid != '0) any_pulse++;
      end
      check("stall_idle_no_grant", any_pulse, 0);
      sp_stable = 1'b1;
      step();
      check("stall_grant_busy", busy, 1);
      step();
      check("stall_no_early_resp", resp_valid, 0);
      sp_stable = 1'b0;
      any_pulse = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (resp_valid != '0) any_pulse++;
      end
      check("stall_no_resp_unstable", any_pulse, 0);
      sp_stable = 1'b1;
      step();
      check("stall_resp_after_1", resp_valid, 0);
      step();
      check("stall_resp_after_2", resp_valid, 4'b0100);
      check("stall_resp_dist", resp_dist, 10);
      check("stall_q_r", q_r, 4);
      req = '0;
      step();

      // async reset mid-WAIT; pointer now 2, so req[1] is granted
      set_coords(3, 3);
      req = 4'b0010;
      step();
      check("rstw_busy", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("rstw_q_r", q_r, 0);
      check("rstw_q_c", q_c, 0);
      check("rstw_resp_dir", resp_dir, 0);
      check("rstw_resp_dist", resp_dist, 0);
      check("rstw_resp_valid", resp_valid, 0);
      check("rstw_busy_low", busy, 0);
      req = '0;
      step();
      step();
      rst = 1'b1;
      any_pulse = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (resp_valid != '0) any_pulse++;
      end
      check("rstw_no_pulse", any_pulse, 0);
      req = 4'b1001;
      wait_resp(n);
      check("rstw_ptr_reset_grant", resp_valid, 4'b0001);
      check("rstw_latency", n, LAT + 1);
      req = '0;
      step();

      // requester drops req after grant; coordinate changes ignored
      set_coords(4, 4);
      stub_dir = 3'd3;
      req = 4'b0110;
      step();
      req = 4'b0100;
      set_coords(20, 20);
      wait_resp(n);
      check("drop_resp_valid", resp_valid, 4'b0010);
      check("drop_q_r_held", q_r, 5);
      check("drop_resp_dist", resp_dist, 11);
      wait_resp(n);
      check("drop_next_grant", resp_valid, 4'b0100);
      check("drop_next_q_r", q_r, 22);
      req = '0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
